// File: rtl/sigma_mem_arbiter_pkg.sv
// Shared widths and the round-robin pick helper for the sigma memory arbiter.
// The helper works on a fixed maximum width so any master count up to eight can use it.
package sigma_mem_arbiter_pkg;

  localparam int MEM_AW      = 32;
  localparam int MEM_DW      = 32;
  localparam int MEM_BEW     = 4;
  localparam int MAX_MASTERS = 8;

  // One-hot grant of the first set request at or above ptr, wrapping modulo n.
  function automatic logic [MAX_MASTERS-1:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                                     input int unsigned n,
                                                     input int unsigned ptr);
    logic [MAX_MASTERS-1:0] grant;
    logic                   found;
    int unsigned            idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < MAX_MASTERS; off++) begin
      if (off < n) begin
        idx = ptr + off;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/sigma_arb_idfifo.sv
// In-order FIFO of master IDs for reads that were accepted but not yet answered.
// Pointers carry one extra MSB so full and empty differ only in that wrap bit.
module sigma_arb_idfifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // NOTE: the storage array has no reset; only the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sigma_mem_arbiter.sv
// Round-robin arbiter sharing one MemSplit32 slave port among several masters,
// with a grant lock while the slave stalls and in-order read response steering.
module sigma_mem_arbiter
  import sigma_mem_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int RD_OUTSTANDING = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [NUM_MASTERS-1:0]         m_req_i,
  output logic [NUM_MASTERS-1:0]         m_ack_o,
  input  logic [NUM_MASTERS*MEM_AW-1:0]  m_addr_i,
  input  logic [NUM_MASTERS-1:0]         m_we_i,
  input  logic [NUM_MASTERS*MEM_DW-1:0]  m_wdata_i,
  input  logic [NUM_MASTERS*MEM_BEW-1:0] m_be_i,
  output logic [NUM_MASTERS-1:0]         m_resp_o,
  output logic [MEM_DW-1:0]              m_rdata_o,
  output logic                           s_req_o,
  input  logic                           s_ack_i,
  output logic [MEM_AW-1:0]              s_addr_o,
  output logic                           s_we_o,
  output logic [MEM_DW-1:0]              s_wdata_o,
  output logic [MEM_BEW-1:0]             s_be_o,
  input  logic                           s_resp_i,
  input  logic [MEM_DW-1:0]              s_rdata_i,
  output logic                           err_o
);

  localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [IDW-1:0]         rr_ptr;
  logic                   lock_valid;
  logic [IDW-1:0]         lock_idx;
  logic [MAX_MASTERS-1:0] elig;
  logic [MAX_MASTERS-1:0] pick;
  logic [MAX_MASTERS-1:0] grant;
  logic [IDW-1:0]         grant_idx;
  logic                   handshake;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [IDW-1:0]         fifo_head;

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_MASTERS; k++)
      elig[k] = m_req_i[k] & (m_we_i[k] | ~fifo_full);
    pick  = rr_pick(elig, NUM_MASTERS, 32'(rr_ptr));
    grant = '0;
    // A held lock pins the grant; if its master gives up, nobody is granted this cycle.
    if (!rst_n_i)        grant = '0;
    else if (lock_valid) grant[lock_idx] = m_req_i[lock_idx];
    else                 grant = pick;
  end

  always_comb begin
    grant_idx = '0;
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_wdata_o = '0;
    s_be_o    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant[k]) begin
        grant_idx = IDW'(k);
        s_addr_o  = m_addr_i[k*MEM_AW +: MEM_AW];
        s_we_o    = m_we_i[k];
        s_wdata_o = m_wdata_i[k*MEM_DW +: MEM_DW];
        s_be_o    = m_be_i[k*MEM_BEW +: MEM_BEW];
      end
    end
  end

  assign s_req_o   = |grant;
  assign handshake = s_req_o & s_ack_i;
  assign m_ack_o   = grant[NUM_MASTERS-1:0] & {NUM_MASTERS{handshake}};
  assign fifo_push = handshake & ~s_we_o;
  assign fifo_pop  = s_resp_i & ~fifo_empty;
  assign m_rdata_o = s_rdata_i;

  always_comb begin
    m_resp_o = '0;
    for (int k = 0; k < NUM_MASTERS; k++)
      m_resp_o[k] = fifo_pop && (fifo_head == IDW'(k));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_idx   <= '0;
      err_o      <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr     <= (grant_idx == IDW'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
        lock_valid <= 1'b0;
      end else if (s_req_o) begin
        lock_valid <= 1'b1;
        lock_idx   <= grant_idx;
      end else begin
        lock_valid <= 1'b0;
      end
      if (s_resp_i && fifo_empty) err_o <= 1'b1;
    end
  end

  sigma_arb_idfifo #(
    .WIDTH (IDW),
    .DEPTH (RD_OUTSTANDING)
  ) u_idfifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (grant_idx),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: doc/sigma_mem_arbiter.md
Name: sigma_mem_arbiter

Overview:
- Shares one MemSplit32 slave port between NUM_MASTERS requesters, e.g. instruction and data ports of several sigma cores onto one memory or xbar port.
- Request phase uses round-robin arbitration with a grant lock.
- Read responses return in order and are steered back to the issuing master through an ID FIFO.
- Writes produce no response.

Parameters:
- NUM_MASTERS, 2, number of requesting MemSplit32 masters (2..8).
- RD_OUTSTANDING, 4, maximum accepted-but-unanswered reads; also the ID FIFO depth (power of two).

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  asynchronous active-low reset
- m_req_i  input  NUM_MASTERS  per-master request
- m_ack_o  output  NUM_MASTERS  per-master request accepted
- m_addr_i  input  NUM_MASTERS*32  per-master address, master k at bits [32k+31:32k]
- m_we_i  input  NUM_MASTERS  per-master write enable
- m_wdata_i  input  NUM_MASTERS*32  per-master write data
- m_be_i  input  NUM_MASTERS*4  per-master byte enables
- m_resp_o  output  NUM_MASTERS  per-master read response valid
- m_rdata_o  output  32  read data, broadcast to all masters
- s_req_o  output  1  slave request
- s_ack_i  input  1  slave accepted request
- s_addr_o  output  32  slave address
- s_we_o  output  1  slave write enable
- s_wdata_o  output  32  slave write data
- s_be_o  output  4  slave byte enables
- s_resp_i  input  1  slave read response valid
- s_rdata_i  input  32  slave read data
- err_o  output  1  sticky: response arrived with no read outstanding

Behaviour:
- Reset (rst_n_i low, asynchronous): rr pointer = 0, lock cleared, ID FIFO empty, err_o = 0. All m_ack_o, m_resp_o and s_req_o are 0 while reset is asserted.
- Eligibility: master k is eligible when m_req_i[k] is 1 and (m_we_i[k] is 1 or the FIFO is not full).
  - When the FIFO is full, reads are blocked and writes still proceed.
- Grant selection (combinational): first eligible master searching from rr pointer upward, modulo NUM_MASTERS.
- Lock: if s_req_o = 1 and s_ack_i = 0 at a clock edge, the current grant is held in a lock register. Next cycle that master is granted regardless of priority, so s_addr_o, s_we_o, s_wdata_o and s_be_o stay stable until ack.
  - The locked master must keep m_req_i high. If it drops m_req_i, the lock releases and s_req_o drops that cycle.
- Slave outputs:
  - s_req_o = 1 when any master is granted; s_addr_o, s_we_o, s_wdata_o, s_be_o mux from the granted master.
  - When nothing is granted, the slave outputs are 0.
- m_ack_o[g] = s_req_o & s_ack_i for granted master g only; zero latency, combinational from s_ack_i.
- On handshake (s_req_o & s_ack_i):
  - rr pointer <= g+1, wrapping to 0 at NUM_MASTERS;
  - lock cleared;
  - if the granted request is a read, g is pushed into the FIFO.
- Response: when s_resp_i = 1 and the FIFO is not empty:
  - m_resp_o[head] = 1 in the same cycle, combinationally;
  - the FIFO pops at the clock edge;
  - m_rdata_o = s_rdata_i at all times.
- Response when the FIFO is empty: no m_resp_o asserted and no pop; err_o <= 1 and stays set until reset.
- Push and pop in the same cycle: both take effect and the count is unchanged.
  - A push on the cycle the FIFO is full cannot occur, because reads are ineligible when full.
- Slave response latency is arbitrary, as low as the cycle after ack. A response cannot arrive in the same cycle as its own ack.

Decomposition:
- Package sigma_mem_arbiter_pkg:
  - MEM_AW = 32, MEM_DW = 32, MEM_BEW = 4;
  - function rr_pick(req vector, pointer) returning the one-hot grant.
- Sub-module sigma_arb_idfifo: synchronous FIFO with asynchronous active-low reset.
  - Width $clog2(NUM_MASTERS), depth RD_OUTSTANDING.
  - Ports: push, pop, wdata, rdata (head), full, empty.
  - Pointer wrap uses one extra MSB.

Test Plan:
1. NUM_MASTERS=2, both masters request reads every cycle, slave acks every cycle and responds 1 cycle later with data = addr. Required: grants alternate 0,1,0,1; each master gets m_resp_o with its own address as rdata, in order.
2. Master 0 requests a write (addr 0x100, wdata 0xDEADBEEF, be 0xF), slave holds s_ack_i low for 3 cycles. Required: s_addr_o, s_wdata_o, s_be_o are stable for 4 cycles; master 1's request during that time is not granted; m_ack_o[0] pulses once; no FIFO push.
3. RD_OUTSTANDING=4, slave acks 4 reads with no responses. Required: 5th read is blocked (s_req_o=0); a concurrent write from master 1 is still acked. After one s_resp_i, the blocked read is granted next cycle.
4. Pulse s_resp_i with no reads outstanding. Required: no m_resp_o; err_o=1 from the next cycle and stays set; rst_n_i low clears it asynchronously.
5. Assert rst_n_i low mid-transaction, with lock active and 2 reads outstanding. Required: outputs drop to 0 immediately; after release, the FIFO is empty, the rr pointer is 0 and master 0 wins the first contested grant.
